// File: rtl/cascade_controller_if.sv
// Signal bundle for the cascade controller: sequence configuration, INTA and the
// sampled cascade bus in; cascade drive, acknowledge and data-bus enables out.
interface cascade_controller_if #(
    parameter int CAS_W  = 3,
    parameter int NUM_SL = 8
);
    logic              spen;
    logic              sngl;
    logic              mode_8086;
    logic [NUM_SL-1:0] icw3;
    logic [CAS_W-1:0]  ir_id;
    logic              inta_n;
    logic [CAS_W-1:0]  cas_in;
    logic [CAS_W-1:0]  cas_out;
    logic              cas_oe;
    logic              ack;
    logic              vec_oe;
    logic [1:0]        byte_sel;
    logic              seq_done;
    logic              abort;

    modport master (
        output spen, sngl, mode_8086, icw3, ir_id, inta_n, cas_in,
        input  cas_out, cas_oe, ack, vec_oe, byte_sel, seq_done, abort
    );

    modport slave (
        input  spen, sngl, mode_8086, icw3, ir_id, inta_n, cas_in,
        output cas_out, cas_oe, ack, vec_oe, byte_sel, seq_done, abort
    );
endinterface

// File: rtl/cascade_controller.sv
// Clocked 8259-style cascade controller: follows the INTA pulse train (2 or 3 pulses),
// drives the slave ID as master, claims the vector bus as a matching slave.
module cascade_controller #(
    parameter int CAS_W   = 3,
    parameter int NUM_SL  = 8,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    cascade_controller_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        P1   = 3'd1,
        G1   = 3'd2,
        P2   = 3'd3,
        G2   = 3'd4,
        P3   = 3'd5
    } state_t;

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

    state_t            state_r, state_s;
    logic [CNT_W-1:0]  cnt_r, cnt_s;
    logic              inta_q_r;
    logic              spen_r, spen_s, sngl_r, sngl_s, mode_r, mode_s;
    logic [NUM_SL-1:0] icw3_r, icw3_s;
    logic [CAS_W-1:0]  ir_id_r, ir_id_s;
    logic              ack_r, ack_s;
    logic              fall_s, rise_s, edge_s;
    logic              casc_s, noncasc_s;
    logic [CAS_W-1:0]  cas_out_r, cas_out_s;
    logic              cas_oe_r, cas_oe_s;
    logic              vec_oe_r, vec_oe_s;
    logic [1:0]        byte_sel_r, byte_sel_s;
    logic              seq_done_r, seq_done_s;
    logic              abort_r, abort_s;

    assign fall_s = inta_q_r & ~bus.inta_n;
    assign rise_s = ~inta_q_r & bus.inta_n;
    assign edge_s = fall_s | rise_s;

    // Next-state, configuration latch, slave match and inter-edge timeout
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        spen_s     = spen_r;
        sngl_s     = sngl_r;
        mode_s     = mode_r;
        icw3_s     = icw3_r;
        ir_id_s    = ir_id_r;
        ack_s      = ack_r;
        seq_done_s = 1'b0;
        abort_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (fall_s) begin
                    state_s = P1;
                    spen_s  = bus.spen;
                    sngl_s  = bus.sngl;
                    mode_s  = bus.mode_8086;
                    icw3_s  = bus.icw3;
                    ir_id_s = bus.ir_id;
                    ack_s   = 1'b0;
                end else begin
                    state_s = IDLE;
                end
            end
            P1: begin
                if (rise_s) begin
                    state_s = G1;
                    ack_s   = ~spen_r & ~sngl_r & (bus.cas_in == icw3_r[CAS_W-1:0]);
                end else begin
                    state_s = P1;
                end
            end
            G1: begin
                if (fall_s) begin
                    state_s = P2;
                end else begin
                    state_s = G1;
                end
            end
            P2: begin
                if (rise_s && mode_r) begin
                    state_s    = IDLE;
                    ack_s      = 1'b0;
                    seq_done_s = 1'b1;
                end else if (rise_s) begin
                    state_s = G2;
                end else begin
                    state_s = P2;
                end
            end
            G2: begin
                if (fall_s) begin
                    state_s = P3;
                end else begin
                    state_s = G2;
                end
            end
            P3: begin
                if (rise_s) begin
                    state_s    = IDLE;
                    ack_s      = 1'b0;
                    seq_done_s = 1'b1;
                end else begin
                    state_s = P3;
                end
            end
            default: begin
                state_s = IDLE;
                ack_s   = 1'b0;
            end
        endcase
        // A detected edge always beats an expiring timeout
        if (edge_s) begin
            cnt_s = {CNT_W{1'b0}};
        end else if (state_r == IDLE) begin
            cnt_s = {CNT_W{1'b0}};
        end else if (cnt_r == CNT_MAX) begin
            state_s = IDLE;
            ack_s   = 1'b0;
            abort_s = 1'b1;
            cnt_s   = {CNT_W{1'b0}};
        end else begin
            cnt_s = cnt_r + CNT_W'(1);
        end
    end

    // Output decode from the upcoming state so outputs change on the edge-detect clock
    always_comb begin
        casc_s    = spen_s & ~sngl_s & icw3_s[ir_id_s];
        noncasc_s = sngl_s | (spen_s & ~casc_s);
        cas_oe_s  = casc_s & (state_s != IDLE);
        if (cas_oe_s) begin
            cas_out_s = ir_id_s;
        end else begin
            cas_out_s = {CAS_W{1'b0}};
        end
        vec_oe_s   = 1'b0;
        byte_sel_s = 2'd0;
        case (state_s)
            P1: begin
                // CALL opcode comes from the master or a standalone part, never a slave
                vec_oe_s   = ~mode_s & (spen_s | sngl_s);
                byte_sel_s = 2'd0;
            end
            P2: begin
                vec_oe_s   = noncasc_s | (~spen_s & ~sngl_s & ack_s);
                byte_sel_s = vec_oe_s ? 2'd1 : 2'd0;
            end
            P3: begin
                vec_oe_s   = noncasc_s | (~spen_s & ~sngl_s & ack_s);
                byte_sel_s = vec_oe_s ? 2'd2 : 2'd0;
            end
            default: begin
                vec_oe_s   = 1'b0;
                byte_sel_s = 2'd0;
            end
        endcase
    end

    // State, latched configuration and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            cnt_r      <= {CNT_W{1'b0}};
            inta_q_r   <= 1'b1;
            spen_r     <= 1'b0;
            sngl_r     <= 1'b0;
            mode_r     <= 1'b0;
            icw3_r     <= {NUM_SL{1'b0}};
            ir_id_r    <= {CAS_W{1'b0}};
            ack_r      <= 1'b0;
            cas_out_r  <= {CAS_W{1'b0}};
            cas_oe_r   <= 1'b0;
            vec_oe_r   <= 1'b0;
            byte_sel_r <= 2'd0;
            seq_done_r <= 1'b0;
            abort_r    <= 1'b0;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            inta_q_r   <= bus.inta_n;
            spen_r     <= spen_s;
            sngl_r     <= sngl_s;
            mode_r     <= mode_s;
            icw3_r     <= icw3_s;
            ir_id_r    <= ir_id_s;
            ack_r      <= ack_s;
            cas_out_r  <= cas_out_s;
            cas_oe_r   <= cas_oe_s;
            vec_oe_r   <= vec_oe_s;
            byte_sel_r <= byte_sel_s;
            seq_done_r <= seq_done_s;
            abort_r    <= abort_s;
        end
    end

    assign bus.cas_out  = cas_out_r;
    assign bus.cas_oe   = cas_oe_r;
    assign bus.ack      = ack_r;
    assign bus.vec_oe   = vec_oe_r;
    assign bus.byte_sel = byte_sel_r;
    assign bus.seq_done = seq_done_r;
    assign bus.abort    = abort_r;
endmodule

// File: tb/tb_cascade_controller.sv
// Bench for cascade_controller: directed vector table, hand-written timeout/reset
// sequences, then random INTA traffic checked against a pulse-counting model.
module tb_cascade_controller;
    localparam int CW = 3;
    localparam int NS = 8;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    cascade_controller_if #(.CAS_W(CW), .NUM_SL(NS)) bus ();

    cascade_controller #(.CAS_W(CW), .NUM_SL(NS), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       inta_n;
        logic       spen;
        logic       sngl;
        logic       mode;
        logic [7:0] icw3;
        logic [2:0] ir_id;
        logic [2:0] cas_in;
        logic [2:0] e_cas_out;
        logic       e_cas_oe;
        logic       e_ack;
        logic       e_vec_oe;
        logic [1:0] e_byte;
        logic       e_done;
        logic       e_abort;
    } vec_t;

    vec_t tbl[$];

    // Reference model: sequence active flag, pulse number, in-pulse flag, idle counter
    logic       m_prev = 1'b1;
    logic       m_active = 1'b0;
    logic       m_low = 1'b0;
    int         m_pulse = 0;
    int         m_cnt = 0;
    logic       m_spen = 1'b0, m_sngl = 1'b0, m_mode = 1'b0, m_ack = 1'b0;
    logic [7:0] m_icw3 = 8'h00;
    logic [2:0] m_ir = 3'd0;
    logic       m_done = 1'b0, m_abort = 1'b0;

    function automatic vec_t mk(input logic i, sp, sg, md, input logic [7:0] ic,
                                input logic [2:0] ir, ci, eco,
                                input logic eoe, eak, evo, input logic [1:0] eb,
                                input logic edn, eab);
        vec_t v;
        v.inta_n = i;  v.spen = sp; v.sngl = sg; v.mode = md; v.icw3 = ic;
        v.ir_id = ir;  v.cas_in = ci; v.e_cas_out = eco; v.e_cas_oe = eoe;
        v.e_ack = eak; v.e_vec_oe = evo; v.e_byte = eb; v.e_done = edn; v.e_abort = eab;
        return v;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_outs(input string tag, input logic [2:0] co, input logic oe,
                              input logic ak, input logic vo, input logic [1:0] bs,
                              input logic dn, input logic ab);
        chk({tag, ".cas_out"}, 8'(bus.cas_out), 8'(co));
        chk({tag, ".cas_oe"}, 8'(bus.cas_oe), 8'(oe));
        chk({tag, ".ack"}, 8'(bus.ack), 8'(ak));
        chk({tag, ".vec_oe"}, 8'(bus.vec_oe), 8'(vo));
        chk({tag, ".byte_sel"}, 8'(bus.byte_sel), 8'(bs));
        chk({tag, ".seq_done"}, 8'(bus.seq_done), 8'(dn));
        chk({tag, ".abort"}, 8'(bus.abort), 8'(ab));
    endtask

    task automatic set_in(input logic i, sp, sg, md, input logic [7:0] ic,
                          input logic [2:0] ir, ci);
        bus.inta_n = i; bus.spen = sp; bus.sngl = sg; bus.mode_8086 = md;
        bus.icw3 = ic; bus.ir_id = ir; bus.cas_in = ci;
    endtask

    task automatic model_reset();
        m_prev = 1'b1; m_active = 1'b0; m_low = 1'b0; m_pulse = 0; m_cnt = 0;
        m_ack = 1'b0; m_done = 1'b0; m_abort = 1'b0;
    endtask

    task automatic model_step();
        logic fall, rise;
        fall = m_prev & ~bus.inta_n;
        rise = ~m_prev & bus.inta_n;
        m_prev = bus.inta_n;
        m_done = 1'b0;
        m_abort = 1'b0;
        if (!m_active) begin
            if (fall) begin
                m_active = 1'b1; m_pulse = 1; m_low = 1'b1; m_cnt = 0; m_ack = 1'b0;
                m_spen = bus.spen; m_sngl = bus.sngl; m_mode = bus.mode_8086;
                m_icw3 = bus.icw3; m_ir = bus.ir_id;
            end
        end else if (fall && !m_low) begin
            m_pulse++; m_low = 1'b1; m_cnt = 0;
        end else if (rise && m_low) begin
            if (m_pulse == 1 && !m_spen && !m_sngl && bus.cas_in == m_icw3[2:0]) m_ack = 1'b1;
            m_low = 1'b0; m_cnt = 0;
            if (m_pulse == (m_mode ? 2 : 3)) begin
                m_active = 1'b0; m_done = 1'b1; m_ack = 1'b0;
            end
        end else if (m_cnt == TO - 1) begin
            m_active = 1'b0; m_abort = 1'b1; m_ack = 1'b0;
        end else begin
            m_cnt++;
        end
    endtask

    task automatic check_model(input string tag);
        logic       casc, noncasc, has, drv, oe;
        logic [1:0] b;
        casc    = m_spen & ~m_sngl & m_icw3[m_ir];
        noncasc = m_sngl | (m_spen & ~casc);
        oe      = m_active & casc;
        has = 1'b0;
        b   = 2'd0;
        if (m_active && m_low) begin
            has = m_mode ? (m_pulse == 2) : 1'b1;
            b   = m_mode ? 2'd1 : 2'(m_pulse - 1);
        end
        drv = noncasc | (casc & (b == 2'd0)) | (~m_spen & ~m_sngl & m_ack & (b != 2'd0));
        check_outs(tag, oe ? m_ir : 3'd0, oe, m_ack, has & drv, (has & drv) ? b : 2'd0,
                   m_done, m_abort);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int hold;
        // Master 8086 cascaded on IR4; config scrambled mid-sequence must be ignored
        tbl.push_back(mk(1, 1, 0, 1, 8'h10, 3'd4, 3'd0, 3'd0, 0, 0, 0, 2'd0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 1, 8'h10, 3'd4, 3'd0, 3'd4, 1, 0, 0, 2'd0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 8'h00, 3'd1, 3'd0, 3'd4, 1, 0, 0, 2'd0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 0, 8'h00, 3'd1, 3'd0, 3'd4, 1, 0, 0, 2'd0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 8'hFF, 3'd7, 3'd0, 3'd4, 1, 0, 0, 2'd0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 1, 8'h10, 3'd4, 3'd0, 3'd0, 0, 0, 0, 2'd0, 1, 0));
        tbl.push_back(mk(1, 1, 0, 1, 8'h10, 3'd4, 3'd0, 3'd0, 0, 0, 0, 2'd0, 0, 0));
        // Master 8080, no slaves: three bytes
        tbl.push_back(mk(0, 1, 0, 0, 8'h00, 3'd2, 3'd0, 3'd0, 0, 0, 1, 2'd0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 8'h00, 3'd2, 3'd0, 3'd0, 0, 0, 1, 2'd0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 8'h00, 3'd2, 3'd0, 3'd0, 0, 0, 0, 2'd0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 8'h00, 3'd2, 3'd0, 3'd0, 0, 0, 1, 2'd1, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 8'h00, 3'd2, 3'd0, 3'd0, 0, 0, 0, 2'd0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 8'h00, 3'd2, 3'd0, 3'd0, 0, 0, 1, 2'd2, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 8'h00, 3'd2, 3'd0, 3'd0, 0, 0, 0, 2'd0, 1, 0));
        tbl.push_back(mk(1, 1, 0, 0, 8'h00, 3'd2, 3'd0, 3'd0, 0, 0, 0, 2'd0, 0, 0));
        // Slave ID3, 8086, CAS_IN matches only at the rise of pulse 1; SPEN toggled later
        tbl.push_back(mk(0, 0, 0, 1, 8'h03, 3'd0, 3'd5, 3'd0, 0, 0, 0, 2'd0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 1, 8'h03, 3'd0, 3'd3, 3'd0, 0, 1, 0, 2'd0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 1, 8'hFF, 3'd0, 3'd5, 3'd0, 0, 1, 1, 2'd1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 1, 8'h03, 3'd0, 3'd5, 3'd0, 0, 0, 0, 2'd0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 1, 8'h03, 3'd0, 3'd5, 3'd0, 0, 0, 0, 2'd0, 0, 0));
        // Slave ID3, CAS_IN = 5: not selected
        tbl.push_back(mk(0, 0, 0, 1, 8'h03, 3'd0, 3'd5, 3'd0, 0, 0, 0, 2'd0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 1, 8'h03, 3'd0, 3'd5, 3'd0, 0, 0, 0, 2'd0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 8'h03, 3'd0, 3'd3, 3'd0, 0, 0, 0, 2'd0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 1, 8'h03, 3'd0, 3'd3, 3'd0, 0, 0, 0, 2'd0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 1, 8'h03, 3'd0, 3'd3, 3'd0, 0, 0, 0, 2'd0, 0, 0));
        // SNGL with SPEN = 0, 8086: behaves as standalone
        tbl.push_back(mk(0, 0, 1, 1, 8'hFF, 3'd1, 3'd0, 3'd0, 0, 0, 0, 2'd0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 1, 8'hFF, 3'd1, 3'd0, 3'd0, 0, 0, 0, 2'd0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 8'hFF, 3'd1, 3'd0, 3'd0, 0, 0, 1, 2'd1, 0, 0));
        tbl.push_back(mk(1, 0, 1, 1, 8'hFF, 3'd1, 3'd0, 3'd0, 0, 0, 0, 2'd0, 1, 0));
        tbl.push_back(mk(1, 0, 1, 1, 8'hFF, 3'd1, 3'd0, 3'd0, 0, 0, 0, 2'd0, 0, 0));

        set_in(1'b1, 1'b1, 1'b0, 1'b1, 8'h10, 3'd4, 3'd0);
        #1;
        check_outs("reset", 3'd0, 0, 0, 0, 2'd0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        foreach (tbl[i]) begin
            set_in(tbl[i].inta_n, tbl[i].spen, tbl[i].sngl, tbl[i].mode, tbl[i].icw3,
                   tbl[i].ir_id, tbl[i].cas_in);
            tick();
            check_outs($sformatf("tbl%0d", i), tbl[i].e_cas_out, tbl[i].e_cas_oe,
                       tbl[i].e_ack, tbl[i].e_vec_oe, tbl[i].e_byte, tbl[i].e_done,
                       tbl[i].e_abort);
        end

        // Timeout after pulse 1, then an immediate restart on the next cycle
        set_in(1'b0, 1'b1, 1'b0, 1'b1, 8'h10, 3'd4, 3'd0);
        tick();
        bus.inta_n = 1'b1;
        tick();
        for (int k = 1; k <= TO; k++) begin
            tick();
            if (k < TO) check_outs($sformatf("to_wait%0d", k), 3'd4, 1, 0, 0, 2'd0, 0, 0);
            else check_outs("to_abort", 3'd0, 0, 0, 0, 2'd0, 0, 1);
        end
        bus.inta_n = 1'b0;
        tick();
        check_outs("to_restart", 3'd4, 1, 0, 0, 2'd0, 0, 0);
        bus.inta_n = 1'b1; tick();
        bus.inta_n = 1'b0; tick();
        bus.inta_n = 1'b1; tick();
        check_outs("to_done", 3'd0, 0, 0, 0, 2'd0, 1, 0);
        tick();

        // Fall lands on the cycle the timeout would fire: edge wins
        bus.inta_n = 1'b0; tick();
        bus.inta_n = 1'b1; tick();
        for (int k = 1; k < TO; k++) tick();
        bus.inta_n = 1'b0;
        tick();
        check_outs("edge_wins", 3'd4, 1, 0, 0, 2'd0, 0, 0);
        bus.inta_n = 1'b1;
        tick();
        check_outs("edge_wins_done", 3'd0, 0, 0, 0, 2'd0, 1, 0);
        tick();

        // Asynchronous reset during P2 of a standalone 8080 sequence
        set_in(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 3'd2, 3'd0);
        tick();
        bus.inta_n = 1'b1; tick();
        bus.inta_n = 1'b0; tick();
        check_outs("p2_before_rst", 3'd0, 0, 0, 1, 2'd1, 0, 0);
        rst_n = 1'b0;
        #1;
        check_outs("async_rst", 3'd0, 0, 0, 0, 2'd0, 0, 0);
        model_reset();
        bus.inta_n = 1'b1;
        #1;
        rst_n = 1'b1;
        tick();
        check_outs("post_rst_idle", 3'd0, 0, 0, 0, 2'd0, 0, 0);
        bus.inta_n = 1'b0;
        tick();
        check_outs("post_rst_p1", 3'd0, 0, 0, 1, 2'd0, 0, 0);
        bus.inta_n = 1'b1;
        tick();

        // Random INTA traffic with changing configuration against the model
        hold = 0;
        for (int i = 0; i < 3000; i++) begin
            if (hold == 0) begin
                bus.inta_n = ~bus.inta_n;
                hold = ($urandom_range(0, 11) == 0) ? TO + 3 : int'($urandom_range(1, 4));
            end
            hold--;
            if ($urandom_range(0, 3) == 0) begin
                bus.spen      = 1'($urandom_range(0, 1));
                bus.sngl      = ($urandom_range(0, 3) == 0);
                bus.mode_8086 = 1'($urandom_range(0, 1));
                bus.icw3      = 8'($urandom_range(0, 255));
                bus.ir_id     = 3'($urandom_range(0, 7));
            end
            bus.cas_in = ($urandom_range(0, 1) == 1) ? bus.icw3[2:0] : 3'($urandom_range(0, 7));
            tick();
            check_model($sformatf("rnd%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cascade_controller.md
Name: cascade_controller

Overview:
- Parametrised, clocked cascade controller for the 8259-style PIC. Replaces the old combinational cascade-match block.
- Tracks the INTA pulse sequence in both 8080 (3-pulse) and 8086 (2-pulse) modes.
- As master, drives the slave ID onto a CAS_W-bit cascade bus. As slave, matches its ID and claims the vector bus.
- Sits between the control logic (IR selection, ICW3, mode bits) and the data-bus buffer output enable.

Parameters:
- CAS_W, 3, cascade address width; the design supports up to NUM_SL slaves.
- NUM_SL, 8, number of IR inputs that may host a slave; must equal 2**CAS_W.
- TIMEOUT, 64, maximum CLK cycles allowed between consecutive INTA edges before the sequence is aborted.

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  asynchronous active-low reset.
- SPEN  in  1  1 = master, 0 = slave; latched at sequence start.
- SNGL  in  1  1 = single PIC, no cascading; latched at sequence start.
- MODE_8086  in  1  1 = 2-pulse sequence, 0 = 3-pulse sequence; latched at sequence start.
- ICW3  in  NUM_SL  master: bit i = 1 means IR i hosts a slave. Slave: bits [CAS_W-1:0] are its own ID.
- IR_ID  in  CAS_W  index of the IR being acknowledged; valid when the first INTA falls.
- INTA_N  in  1  interrupt acknowledge, active low, already synchronous to CLK.
- CAS_IN  in  CAS_W  sampled cascade bus.
- CAS_OUT  out  CAS_W  cascade bus drive value.
- CAS_OE  out  1  cascade bus output enable.
- ACK  out  1  slave: this device was selected for the current sequence.
- VEC_OE  out  1  this device drives the data bus during the current pulse.
- BYTE_SEL  out  2  byte being supplied: 0 = CALL opcode, 1 = first vector byte, 2 = second vector byte.
- SEQ_DONE  out  1  one-cycle pulse after the final pulse rises.
- ABORT  out  1  one-cycle pulse on timeout.

Behaviour:
- Reset values (asynchronous): all outputs 0, state IDLE, timeout counter 0, internal INTA_N_q = 1.
- Edge detection: fall = INTA_N_q & ~INTA_N; rise = ~INTA_N_q & INTA_N. All outputs are registered and update on the same CLK edge at which the edge is detected, so they are visible 1 cycle after INTA_N is first sampled at its new level.
- States: IDLE, P1, G1, P2, G2, P3.
  - IDLE -fall-> P1.
  - P1 -rise-> G1.
  - G1 -fall-> P2.
  - P2 -rise-> IDLE if mode8086, else G2.
  - G2 -fall-> P3.
  - P3 -rise-> IDLE.
  - Returning to IDLE from P2 or P3 pulses SEQ_DONE.
- Latch on IDLE -> P1: SPEN, SNGL, MODE_8086, ICW3, IR_ID. Later changes to these inputs are ignored until IDLE.
  - cascaded = master & ~SNGL & ICW3[IR_ID].
- Master with cascaded = 1:
  - CAS_OUT = IR_ID and CAS_OE = 1 from entry to P1 until the return to IDLE.
  - 8080 mode: VEC_OE = 1 in P1 only, with BYTE_SEL = 0.
  - 8086 mode: VEC_OE is never asserted.
- Master with cascaded = 0, or SNGL = 1 (regardless of SPEN):
  - CAS_OE = 0 and CAS_OUT = 0.
  - 8086 mode: VEC_OE = 1 in P2, BYTE_SEL = 1.
  - 8080 mode: VEC_OE = 1 in P1, P2 and P3, with BYTE_SEL = 0, 1, 2 respectively.
- Slave (SPEN = 0, SNGL = 0):
  - CAS_OE is held at 0.
  - CAS_IN is compared with the latched ICW3[CAS_W-1:0] on the P1 -> G1 transition (rise of pulse 1).
  - On a match, ACK = 1 until IDLE; otherwise ACK stays 0.
  - With ACK = 1: 8086 mode gives VEC_OE in P2 (BYTE_SEL = 1); 8080 mode gives VEC_OE in P2 and P3 (BYTE_SEL = 1, 2).
  - A slave never drives BYTE_SEL = 0.
- VEC_OE falls in the same cycle that the state leaves its pulse state.
- BYTE_SEL is 0 whenever VEC_OE = 0.
- Timeout:
  - The counter clears on every detected edge and counts each cycle while not in IDLE.
  - When it reaches TIMEOUT-1, the FSM goes to IDLE, pulses ABORT, and clears CAS_OE, ACK and VEC_OE.
  - SEQ_DONE is not pulsed on an abort.
- Precedence: if an edge and the timeout occur in the same cycle, the edge wins. RST_N low overrides everything mid-sequence.
- A fall detected on the cycle immediately after SEQ_DONE or ABORT starts a new sequence normally.

Test Plan:
- Master, 8086, SNGL = 0, ICW3 = 8'h10, IR_ID = 4, two INTA pulses.
  - CAS_OUT = 3'd4 and CAS_OE = 1 from 1 cycle after the first fall until the final rise.
  - VEC_OE stays 0; SEQ_DONE pulses once.
- Master, 8080, ICW3 = 0, IR_ID = 2, three pulses.
  - CAS_OE = 0; VEC_OE is high during each pulse with BYTE_SEL = 0, 1, 2.
- Slave, ID 3, 8086, CAS_IN = 3 at the rise of pulse 1.
  - ACK = 1; VEC_OE with BYTE_SEL = 1 during pulse 2 only.
  - Repeat with CAS_IN = 5: ACK and VEC_OE stay 0.
- Master, 8086, cascaded: hold INTA_N high for TIMEOUT cycles after pulse 1.
  - ABORT pulses, CAS_OE drops, no SEQ_DONE; the next fall restarts from P1.
- Toggle SPEN and ICW3 mid-sequence.
  - No change to CAS_OUT, CAS_OE or ACK until IDLE.
- Assert RST_N low during P2.
  - All outputs are 0 immediately, asynchronously; the next fall after release enters P1.
